// File: rtl/pc_pkg.sv
// ============================================================================
// Module : pc_pkg
// Brief  : Shared constants for the program-counter unit: FSM state codes,
//          redirect-source select codes and default vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   typedef logic [2:0] pc_sel_t;

   localparam pc_sel_t SEL_SEQ  = 3'd0;
   localparam pc_sel_t SEL_JMP  = 3'd1;
   localparam pc_sel_t SEL_BR   = 3'd2;
   localparam pc_sel_t SEL_PEND = 3'd3;
   localparam pc_sel_t SEL_ERET = 3'd4;
   localparam pc_sel_t SEL_EXC  = 3'd5;

   localparam logic [31:0] PC_RESET_VEC   = 32'h0040_0000;
   localparam logic [31:0] PC_EXC_VEC     = 32'h0040_0004;
   localparam int          PC_INSTR_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/pc_ctrl_if.sv
// ============================================================================
// Module : pc_ctrl_if
// Brief  : Redirect-request / fetch-PC bundle between the pipeline (master)
//          and the program-counter unit (slave).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              stall;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic              jmp_valid;
   logic [ADDR_W-1:0] jmp_target;
   logic              exc_req;
   logic [ADDR_W-1:0] exc_pc;
   logic              eret;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] pc_next_seq;
   logic [ADDR_W-1:0] epc_out;
   logic              pend_valid;
   logic              misalign;

   modport master (
      output stall, br_taken, br_target, jmp_valid, jmp_target,
             exc_req, exc_pc, eret,
      input  pc_out, pc_next_seq, epc_out, pend_valid, misalign
   );

   modport slave (
      input  stall, br_taken, br_target, jmp_valid, jmp_target,
             exc_req, exc_pc, eret,
      output pc_out, pc_next_seq, epc_out, pend_valid, misalign
   );
endinterface

`default_nettype wire

// File: rtl/pc_redirect_arb.sv
// ============================================================================
// Module : pc_redirect_arb
// Brief  : Combinational redirect priority select:
//          exc > eret > pending > branch > jump > sequential.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_redirect_arb
   import pc_pkg::*;
#(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(PC_EXC_VEC)
) (
   input  logic              exc_req,
   input  logic              eret,
   input  logic              pend_valid,
   input  logic              br_taken,
   input  logic              jmp_valid,
   input  logic [ADDR_W-1:0] epc,
   input  logic [ADDR_W-1:0] pend_target,
   input  logic [ADDR_W-1:0] br_target,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic [ADDR_W-1:0] pc_seq,
   output pc_sel_t           sel,
   output logic [ADDR_W-1:0] target
);

   always_comb begin
      sel    = SEL_SEQ;
      target = pc_seq;
      if (exc_req) begin
         sel    = SEL_EXC;
         target = EXC_VEC;
      end else if (eret) begin
         sel    = SEL_ERET;
         target = epc;
      end else if (pend_valid) begin
         sel    = SEL_PEND;
         target = pend_target;
      end else if (br_taken) begin
         sel    = SEL_BR;
         target = br_target;
      end else if (jmp_valid) begin
         sel    = SEL_JMP;
         target = jmp_target;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_ctrl.sv
// ============================================================================
// Module : pc_ctrl
// Brief  : Fetch program counter with redirect arbitration, stall-time
//          redirect latching, EPC capture and misaligned-target trapping.
//          Define PC_REDIRECT_CNT_EN to add the saturating redirect_cnt port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_ctrl
   import pc_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(PC_RESET_VEC),
   parameter logic [ADDR_W-1:0] EXC_VEC     = ADDR_W'(PC_EXC_VEC),
   parameter int                INSTR_BYTES = PC_INSTR_BYTES
) (
   input  logic        clk,
   input  logic        rst,
   pc_ctrl_if.slave    bus
`ifdef PC_REDIRECT_CNT_EN
   ,
   output logic [31:0] redirect_cnt
`endif
);

   localparam int ALIGN_W = $clog2(INSTR_BYTES);

   logic [0:0]        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, r_epc, r_pend_target;
   logic [ADDR_W-1:0] w_pc_seq, w_arb_target, w_pc_nxt;
   pc_sel_t           w_sel;
   logic              r_misalign;
   logic              w_pend_valid, w_load, w_latch, w_checked, w_mis_bits, w_mis, w_redirect;
   logic              w_any_req;

   assign w_pc_seq  = r_pc + ADDR_W'(INSTR_BYTES);
   assign w_any_req = bus.br_taken | bus.jmp_valid;

   pc_redirect_arb #(
      .ADDR_W  (ADDR_W),
      .EXC_VEC (EXC_VEC)
   ) u_arb (
      .exc_req     (bus.exc_req),
      .eret        (bus.eret),
      .pend_valid  (w_pend_valid),
      .br_taken    (bus.br_taken),
      .jmp_valid   (bus.jmp_valid),
      .epc         (r_epc),
      .pend_target (r_pend_target),
      .br_target   (bus.br_target),
      .jmp_target  (bus.jmp_target),
      .pc_seq      (w_pc_seq),
      .sel         (w_sel),
      .target      (w_arb_target)
   );

   generate
      if (ALIGN_W > 0) begin : g_align_chk
         assign w_mis_bits = |w_arb_target[ALIGN_W-1:0];
      end else begin : g_no_align_chk
         assign w_mis_bits = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.exc_req || bus.eret)
         w_state_nxt = ST_RUN;
      else if (r_state == ST_RUN && bus.stall && w_any_req)
         w_state_nxt = ST_HOLD;
      else if (r_state == ST_HOLD && !bus.stall)
         w_state_nxt = ST_RUN;
   end

   // exc/eret bypass the stall; only br/jmp/pending targets are alignment-checked
   always_comb begin
      w_pend_valid = (r_state == ST_HOLD);
      w_load       = bus.exc_req | bus.eret | ~bus.stall;
      w_latch      = (r_state == ST_RUN) && bus.stall && w_any_req && !bus.exc_req && !bus.eret;
      w_checked    = (w_sel == SEL_BR) || (w_sel == SEL_JMP) || (w_sel == SEL_PEND);
      w_mis        = w_load && w_checked && w_mis_bits;
      w_pc_nxt     = w_mis ? EXC_VEC : w_arb_target;
      w_redirect   = w_load && (w_sel != SEL_SEQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_VEC;
         r_epc         <= '0;
         r_pend_target <= '0;
         r_misalign    <= 1'b0;
      end else begin
         if (w_load)
            r_pc <= w_pc_nxt;
         if (bus.exc_req)
            r_epc <= bus.exc_pc;
         else if (w_mis)
            r_epc <= w_arb_target;
         if (w_latch)
            r_pend_target <= w_arb_target;
         r_misalign <= w_mis;
      end
   end

`ifdef PC_REDIRECT_CNT_EN
   logic [31:0] r_redirect_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_redirect_cnt <= '0;
      else if (w_redirect && (r_redirect_cnt != 32'hFFFF_FFFF))
         r_redirect_cnt <= r_redirect_cnt + 32'd1;
   end

   assign redirect_cnt = r_redirect_cnt;
`else
   logic w_unused_redirect;
   assign w_unused_redirect = w_redirect;
`endif

   assign bus.pc_out      = r_pc;
   assign bus.pc_next_seq = w_pc_seq;
   assign bus.epc_out     = r_epc;
   assign bus.pend_valid  = w_pend_valid;
   assign bus.misalign    = r_misalign;

endmodule

`default_nettype wire

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Parametrised program-counter unit for the MIPS-style pipelined CPU; replaces the single-register PC.
- Holds the fetch PC and computes sequential next-PC.
- Arbitrates branch, jump, exception and ERET redirects, and latches redirects that arrive while fetch is stalled.
- Captures the EPC on exceptions and detects misaligned redirect targets.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 32'h00400000, PC value after reset.
- EXC_VEC, 32'h00400004, exception handler entry address.
- INSTR_BYTES, 4, sequential increment; must be a power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC (fetch back-pressure).
- br_taken  in  1  branch redirect request from EX.
- br_target  in  ADDR_W  branch target.
- jmp_valid  in  1  jump redirect request from ID.
- jmp_target  in  ADDR_W  jump target.
- exc_req  in  1  exception request.
- exc_pc  in  ADDR_W  PC of the faulting instruction.
- eret  in  1  return from exception.
- pc_out  out  ADDR_W  current fetch PC.
- pc_next_seq  out  ADDR_W  pc_out + INSTR_BYTES.
- epc_out  out  ADDR_W  saved exception PC.
- pend_valid  out  1  a redirect is latched awaiting stall release.
- misalign  out  1  one-cycle pulse when a misaligned target is trapped.

Behaviour:
- Reset (async, on rst high):
  - pc_out = RESET_VEC.
  - epc_out = 0.
  - pend_valid = 0, misalign = 0.
  - State = RUN.
- pc_next_seq is combinational; addition is modulo 2^ADDR_W, so pc_out = all-ones-minus-3 wraps to 0.
- Redirect priority, evaluated every cycle: exc_req > eret > pending > br_taken > jmp_valid > sequential.
- Exception:
  - exc_req acts regardless of stall.
  - Next pc_out = EXC_VEC; epc_out <= exc_pc.
  - Pending redirect is cleared; state = RUN.
- ERET:
  - Acts regardless of stall.
  - Next pc_out = epc_out; pending cleared; epc_out unchanged.
- Simultaneous exc_req and eret: exception wins; epc_out <= exc_pc.
- States RUN and HOLD:
  - RUN, stall=0: pc_out <= selected target (1-cycle latency).
  - RUN, stall=1, br_taken or jmp_valid: latch the higher-priority target into the pending register; pend_valid=1; go to HOLD. pc_out is held.
  - RUN, stall=1, no redirect: pc_out is held.
  - HOLD, stall=1: pc_out is held. A new br/jmp does not overwrite the pending target, because the older instruction's redirect wins.
  - HOLD, stall=0: pc_out <= pending target, ignoring concurrent br/jmp; pend_valid=0; go to RUN.
- Misalignment:
  - Applies when the selected br/jmp/pending target has any bit below log2(INSTR_BYTES) set.
  - pc_out <= EXC_VEC; epc_out <= offending target; misalign pulses for 1 cycle.
  - The check applies only when the target is actually loaded, not when it is latched.
  - EXC_VEC and eret targets are not checked.
- Reset mid-HOLD: pending is discarded immediately; PC returns to RESET_VEC.

Optional Feature:
- Macro: PC_REDIRECT_CNT_EN.
- When defined:
  - Adds output redirect_cnt [31:0].
  - Increments by 1 on every cycle pc_out is loaded with a non-sequential value (exc, eret, pending, br, jmp, misalign trap).
  - Saturates at 32'hFFFFFFFF.
  - Resets to 0.
- When undefined: the port and counter do not exist, with zero area cost.

Decomposition:
- Package pc_pkg holds:
  - State encoding localparams ST_RUN = 1'b0, ST_HOLD = 1'b1.
  - Redirect-source select codes SEL_SEQ, SEL_JMP, SEL_BR, SEL_PEND, SEL_ERET, SEL_EXC.
  - Default vector constants.
- One natural sub-module: pc_redirect_arb.
  - Purely combinational priority select.
  - Outputs the select code and target.
  - Instantiated once in pc_ctrl.

Test Plan:
- Reset then 3 cycles, stall=0: pc_out = 00400000, 00400004, 00400008, 0040000C; epc_out = 0.
- stall=1 with br_taken=1, br_target=00400100 for 1 cycle, stall held 2 more cycles with jmp_valid=1, jmp_target=00400200; release stall: pend_valid=1 during hold, then pc_out = 00400100 (not 00400200), pend_valid=0.
- exc_req=1, exc_pc=00400010 while stall=1 and pending set: next pc_out = 00400004, epc_out = 00400010, pend_valid=0. Later eret=1 → pc_out = 00400010.
- br_taken=1, br_target=00400102: next pc_out = 00400004, epc_out = 00400102, misalign high for exactly 1 cycle.
- Simultaneous exc_req, eret and br_taken: exception path taken. pc_out = FFFFFFFC with no redirect → next pc_out = 00000000.
- Assert rst asynchronously mid-HOLD: pc_out = 00400000 before the next clk edge, pend_valid=0. With PC_REDIRECT_CNT_EN, the counter reads 0 after reset and 3 after three redirects.
